// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of the async FIFO, living entirely in the rclk domain.
// It owns the read pointer and derives empty / almost-empty / level from the
// write pointer that has already been synchronised into rclk. It also issues
// reads to the synchronous dual-port RAM and presents the words as a
// first-word-fall-through stream through a 2-entry output buffer.
//
// Handshake: a word moves out on dout when dout_valid and dout_ready are both
// high in the same rclk cycle. dout_valid never depends on dout_ready, and
// dout holds steady while dout_valid is high and dout_ready is low.
//
// Ports
//   rclk, rrst_n    read clock, asynchronous active-low reset
//   rq2_wptr        synchronised write pointer (Gray, ADDR_WIDTH+1 bits)
//   mem_rdata       RAM read data, valid the cycle after mem_ren
//   dout_ready      consumer accepts dout this cycle
//   rptr            registered Gray read pointer, goes to the write-side sync
//   raddr           RAM read address (low bits of the binary read pointer)
//   mem_ren         RAM read enable (combinational)
//   rempty          registered: RAM holds no unread word
//   r_almost_empty  rlevel <= AE_THRESH
//   rlevel          words in RAM not yet read, as seen in rclk
//   dout/dout_valid head of the output buffer
// ----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  mem_ren,
    output logic                  rempty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbinnext;
    logic [PW-1:0]         rgraynext;
    logic [PW-1:0]         wbin;
    logic                  pend;      // a RAM read was issued last cycle
    logic [1:0]            out_cnt;   // words held in the output buffer
    logic [DATA_WIDTH-1:0] buf0;      // oldest entry, drives dout
    logic [DATA_WIDTH-1:0] buf1;
    logic                  pop;
    logic [2:0]            occ;       // buffer occupancy after this cycle, before a new read
    logic [1:0]            slot;      // buffer index the returning word lands in

    assign dout_valid = (out_cnt != 2'd0);
    assign dout       = buf0;
    assign pop        = dout_valid & dout_ready;
    assign raddr      = rbin[ADDR_WIDTH-1:0];

    // Words already buffered plus the one in flight, minus the one leaving.
    // Only issue a read when that leaves room, so the buffer can never overflow.
    assign occ     = {1'b0, out_cnt} + {2'b00, pend} - {2'b00, pop};
    assign mem_ren = !rempty && (occ < 3'd2);

    assign rbinnext  = rbin + {{ADDR_WIDTH{1'b0}}, mem_ren};
    assign rgraynext = rbinnext ^ (rbinnext >> 1);

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Counts only what is still in RAM; buffered and in-flight words are excluded.
    assign rlevel         = wbin - rbin;
    assign r_almost_empty = (rlevel <= AE_LIMIT);

    // A popped head shifts down first, so the arriving word goes to the
    // first free slot after the pop.
    assign slot = out_cnt - {1'b0, pop};

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            pend    <= 1'b0;
            out_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            rbin    <= rbinnext;
            rptr    <= rgraynext;
            // Full-width compare keeps a wrapped (full) RAM distinct from empty.
            rempty  <= (rgraynext == rq2_wptr);
            pend    <= mem_ren;
            out_cnt <= out_cnt + {1'b0, pend} - {1'b0, pop};
            if (pop) begin
                buf0 <= buf1;
            end
            if (pend) begin
                if (slot == 2'd0) begin
                    buf0 <= mem_rdata;
                end else begin
                    buf1 <= mem_rdata;
                end
            end
        end
    end

endmodule
